// File: rtl/dbus_to_cbus_wbuf.sv
// Buffered DBus-to-CBus bridge: stores are posted into a small FIFO and acked at once,
// loads go out on CBus only after every buffered store has been written.
package dbus_to_cbus_wbuf_pkg;
    typedef logic [2:0] msize_t;
    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1 = 4'b0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } state_t;
endpackage

// Handshake: a CBus beat completes on a posedge where dcreq.valid && dcresp.ready && dcresp.last;
// dcreq holds every field stable from valid rising until that edge. DBus requests complete in any
// cycle where addr_ok && data_ok are high; the core holds dreq stable until then.
module dbus_to_cbus_wbuf
    import dbus_to_cbus_wbuf_pkg::*;
#(
    parameter int WBUF_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  dbus_req_t                            dreq,
    output dbus_resp_t                           dresp,
    output cbus_req_t                            dcreq,
    input  cbus_resp_t                           dcresp,
    output logic [$clog2(WBUF_DEPTH+1)-1:0]      wbuf_count,
    output state_t                               dbg_state
);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = $clog2(WBUF_DEPTH + 1);

    logic [31:0]   addr_q   [WBUF_DEPTH];
    msize_t        size_q   [WBUF_DEPTH];
    logic [3:0]    strobe_q [WBUF_DEPTH];
    logic [31:0]   data_q   [WBUF_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    state_t        state;

    logic is_store;
    logic is_load;
    logic full;
    logic push;
    logic pop;
    logic read_done;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign is_store  = dreq.valid && (|dreq.strobe);
    assign is_load   = dreq.valid && (dreq.strobe == 4'b0000);
    assign full      = (count == CW'(WBUF_DEPTH));
    assign push      = !reset && is_store && !full;
    assign pop       = !reset && (state == DRAIN) && dcresp.ready && dcresp.last;
    assign read_done = !reset && (state == READ) && dcresp.ready && dcresp.last;

    assign wbuf_count = count;
    assign dbg_state  = state;

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = push || read_done;
        dresp.data_ok = push || read_done;
        dresp.data    = dcresp.data;
    end

    // Entry storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail]   <= dreq.addr;
            size_q[tail]   <= dreq.size;
            strobe_q[tail] <= dreq.strobe;
            data_q[tail]   <= dreq.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            dcreq <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            case (state)
                IDLE: begin
                    // Pending stores always win over a waiting load to keep program order.
                    if (count != '0) begin
                        state <= DRAIN;
                        dcreq <= '{valid: 1'b1, is_write: 1'b1, size: size_q[head],
                                   addr: addr_q[head], strobe: strobe_q[head],
                                   data: data_q[head], len: MLEN1};
                    end else if (is_load) begin
                        state <= READ;
                        dcreq <= '{valid: 1'b1, is_write: 1'b0, size: dreq.size,
                                   addr: dreq.addr, strobe: 4'b0000,
                                   data: 32'h0, len: MLEN1};
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        state       <= IDLE;
                        dcreq.valid <= 1'b0;
                    end
                end
                READ: begin
                    if (read_done) begin
                        state       <= IDLE;
                        dcreq.valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    dcreq.valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
